// File: rtl/status_value_queue.sv
// In-order status queue: entries are pushed in order, completed by tag in any
// order, and retired oldest-first once the oldest entry holds its value.
module status_value_queue #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int TW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             flush_i,
    input  logic             push_i,
    output logic [TW-1:0]    push_tag_o,
    input  logic             upd_i,
    input  logic [TW-1:0]    upd_tag_i,
    input  logic [WIDTH-1:0] upd_value_i,
    input  logic             pull_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] value_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [TW:0]      count_o
);

    localparam logic [TW:0] PTR_ONE  = (TW+1)'(1);
    localparam logic [TW:0] FULL_CNT = (TW+1)'(DEPTH);

    logic [DEPTH-1:0]            alloc_q, alloc_d;
    logic [DEPTH-1:0]            done_q, done_d;
    logic [DEPTH-1:0][WIDTH-1:0] value_q, value_d;
    logic [TW:0]                 head_q, head_d;
    logic [TW:0]                 tail_q, tail_d;

    logic [TW-1:0] head_idx_s;
    logic [TW-1:0] tail_idx_s;
    logic [TW:0]   count_s;
    logic          full_s;
    logic          valid_s;
    logic          push_acc_s;
    logic          upd_acc_s;
    logic          pull_acc_s;

    // The wrap bit in each pointer separates a full queue from an empty one.
    assign head_idx_s = head_q[TW-1:0];
    assign tail_idx_s = tail_q[TW-1:0];
    assign count_s    = tail_q - head_q;
    assign full_s     = (count_s == FULL_CNT);
    assign valid_s    = alloc_q[head_idx_s] & done_q[head_idx_s];
    assign push_acc_s = push_i & ~full_s;
    assign upd_acc_s  = upd_i & alloc_q[upd_tag_i] & ~done_q[upd_tag_i];
    assign pull_acc_s = pull_i & valid_s;

    assign push_tag_o = tail_idx_s;
    assign valid_o    = valid_s;
    assign value_o    = value_q[head_idx_s];
    assign full_o     = full_s;
    assign empty_o    = (count_s == '0);
    assign count_o    = count_s;

    // Next-state: pull, update and push touch disjoint entries, so their order here is irrelevant.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            alloc_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (pull_acc_s) begin
                alloc_d[head_idx_s] = 1'b0;
                done_d[head_idx_s]  = 1'b0;
                head_d              = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (upd_acc_s) begin
                done_d[upd_tag_i]  = 1'b1;
                value_d[upd_tag_i] = upd_value_i;
            end else begin
                value_d = value_q;
            end
            if (push_acc_s) begin
                alloc_d[tail_idx_s] = 1'b1;
                done_d[tail_idx_s]  = 1'b0;
                tail_d              = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // State registers; values survive flush but are zeroed by reset.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            value_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            done_q  <= done_d;
            value_q <= value_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_status_value_queue.sv
// Directed and random stimulus for status_value_queue, checked against an
// ordered-list model of outstanding entries.
module tb_status_value_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int TW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rsn_i;
    logic             flush_i;
    logic             push_i;
    logic [TW-1:0]    push_tag_o;
    logic             upd_i;
    logic [TW-1:0]    upd_tag_i;
    logic [WIDTH-1:0] upd_value_i;
    logic             pull_i;
    logic             valid_o;
    logic [WIDTH-1:0] value_o;
    logic             full_o;
    logic             empty_o;
    logic [TW:0]      count_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [TW-1:0]    tag;
        logic             done;
        logic [WIDTH-1:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_tag = 0;

    status_value_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rsn_i(rsn_i), .flush_i(flush_i), .push_i(push_i),
        .push_tag_o(push_tag_o), .upd_i(upd_i), .upd_tag_i(upd_tag_i),
        .upd_value_i(upd_value_i), .pull_i(pull_i), .valid_o(valid_o),
        .value_o(value_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int  sz;
        logic ev;
        sz = mq.size();
        ev = (sz > 0) && mq[0].done;
        chk("count", 32'(count_o), sz);
        chk("empty", 32'(empty_o), 32'(sz == 0));
        chk("full", 32'(full_o), 32'(sz == DEPTH));
        chk("push_tag", 32'(push_tag_o), m_tag);
        chk("valid", 32'(valid_o), 32'(ev));
        if (ev) chk("value", 32'(value_o), 32'(mq[0].val));
    endtask

    task automatic model_step(input logic p, input logic u, input logic [TW-1:0] t,
                              input logic [WIDTH-1:0] v, input logic pl, input logic fl);
        logic pull_ok;
        logic push_ok;
        ent_t e;
        if (fl) begin
            mq.delete();
            m_tag = 0;
        end else begin
            pull_ok = pl && (mq.size() > 0) && mq[0].done;
            push_ok = p && (mq.size() < DEPTH);
            if (u) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].tag == t && !mq[i].done) begin
                        e = mq[i];
                        e.done = 1'b1;
                        e.val = v;
                        mq[i] = e;
                    end
                end
            end
            if (pull_ok) void'(mq.pop_front());
            if (push_ok) begin
                e.tag  = TW'(m_tag);
                e.done = 1'b0;
                e.val  = '0;
                mq.push_back(e);
                m_tag = (m_tag + 1) % DEPTH;
            end
        end
    endtask

    task automatic step(input logic p, input logic u, input logic [TW-1:0] t,
                        input logic [WIDTH-1:0] v, input logic pl, input logic fl);
        push_i = p; upd_i = u; upd_tag_i = t; upd_value_i = v; pull_i = pl; flush_i = fl;
        @(negedge clk);
        check_outputs();
        model_step(p, u, t, v, pl, fl);
        @(posedge clk);
        #1;
        push_i = 1'b0; upd_i = 1'b0; upd_tag_i = '0; upd_value_i = '0; pull_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic [TW-1:0]    t;
        rsn_i = 1'b0; flush_i = 1'b0; push_i = 1'b0; upd_i = 1'b0;
        upd_tag_i = '0; upd_value_i = '0; pull_i = 1'b0;

        // Reset then idle
        @(negedge clk);
        check_outputs();
        chk("rst_value", 32'(value_o), 0);
        repeat (2) @(posedge clk);
        #1 rsn_i = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, TW'(i), 8'h5A, 1'b1, 1'b0);
        chk("idle_empty", 32'(empty_o), 1);
        chk("idle_count", 32'(count_o), 0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_tag", 32'(push_tag_o), i);
            step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        end
        chk("fill_full", 32'(full_o), 1);
        chk("fill_count", 32'(count_o), DEPTH);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("ovf_count", 32'(count_o), DEPTH);
        step(1'b0, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("ovf_pull_count", 32'(count_o), DEPTH - 1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

        // Out-of-order completion
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 8'hC2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'hB1, 1'b0, 1'b0);
        chk("ooo_notvalid", 32'(valid_o), 0);
        step(1'b0, 1'b1, 2'd0, 8'hA0, 1'b0, 1'b0);
        chk("ooo_valid", 32'(valid_o), 1);
        chk("ooo_v0", 32'(value_o), 32'hA0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("ooo_v1", 32'(value_o), 32'hB1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("ooo_v2", 32'(value_o), 32'hC2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("ooo_empty", 32'(empty_o), 1);

        // Illegal updates
        step(1'b0, 1'b1, 2'd3, 8'h55, 1'b0, 1'b0);
        chk("unalloc_valid", 32'(valid_o), 0);
        chk("unalloc_count", 32'(count_o), 0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0);
        chk("redo_value", 32'(value_o), 32'h33);
        step(1'b1, 1'b1, 2'd0, 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("samecyc_valid", 32'(valid_o), 0);
        chk("samecyc_count", 32'(count_o), 1);
        step(1'b0, 1'b1, 2'd0, 8'h44, 1'b0, 1'b0);
        chk("late_value", 32'(value_o), 32'h44);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // Wrap-around, one entry at a time
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            v = WIDTH'($urandom);
            t = TW'(i % DEPTH);
            chk("wrap_tag", 32'(push_tag_o), 32'(t));
            step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
            step(1'b0, 1'b1, t, v, 1'b0, 1'b0);
            chk("wrap_value", 32'(value_o), 32'(v));
            chk("wrap_cnt_le1", 32'(count_o <= 1), 1);
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        end

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'($urandom),
                 WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
        end

        // Flush mid-operation
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 8'h9C, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 8'h12, 1'b1, 1'b1);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_tag", 32'(push_tag_o), 0);
        chk("flush_valid", 32'(valid_o), 0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 8'h6B, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(valid_o), 1);
        #2 rsn_i = 1'b0;
        #1;
        mq.delete();
        m_tag = 0;
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_value", 32'(value_o), 0);
        chk("arst_full", 32'(full_o), 0);
        chk("arst_empty", 32'(empty_o), 1);
        chk("arst_count", 32'(count_o), 0);
        chk("arst_tag", 32'(push_tag_o), 0);
        @(posedge clk);
        #1 rsn_i = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
